// File: rtl/satd_pkg.sv
// Shared widths, FSM encoding and constant helpers for the SATD accumulator slice.
package satd_pkg;

  localparam int NUM_COEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int iw(input int length);
    return length + 5;
  endfunction

  function automatic int acc_w(input int length, input int beats);
    return iw(length) + 3 + clog2(beats);
  endfunction

  // Round-half-up bias added before the final right shift.
  function automatic int rnd_bias(input int shift);
    if (shift > 0) return 32'sd1 <<< (shift - 1);
    else return 0;
  endfunction

endpackage

// File: rtl/abs_sum8.sv
// S1: registered absolute values of eight signed coefficients; S2: registered adder tree.
module abs_sum8
  import satd_pkg::*;
#(
  parameter int IW = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_en,
  input  logic signed [IW-1:0] x [NUM_COEF],
  input  logic                 s1_en,
  output logic        [IW+2:0] sum_q
);

  localparam logic [IW-1:0] ONE = {{(IW-1){1'b0}}, 1'b1};

  logic [IW-1:0] abs_d [NUM_COEF];
  logic [IW-1:0] abs_q [NUM_COEF];
  logic [IW:0]   l1_s  [4];
  logic [IW+1:0] l2_s  [2];
  logic [IW+2:0] sum_d;

  // Most-negative input maps to 2^(IW-1), representable as unsigned IW bits.
  always_comb begin
    for (int k = 0; k < NUM_COEF; k++) begin
      if (x[k][IW-1]) abs_d[k] = $unsigned(~x[k]) + ONE;
      else            abs_d[k] = $unsigned(x[k]);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) l1_s[i] = {1'b0, abs_q[2*i]} + {1'b0, abs_q[2*i+1]};
    for (int i = 0; i < 2; i++) l2_s[i] = {1'b0, l1_s[2*i]} + {1'b0, l1_s[2*i+1]};
    sum_d = {1'b0, l2_s[0]} + {1'b0, l2_s[1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_COEF; k++) abs_q[k] <= '0;
      sum_q <= '0;
    end else begin
      if (in_en) abs_q <= abs_d;
      if (s1_en) sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/satd_accumulator.sv
// Block SATD: |x| + adder tree (abs_sum8), beat counter/FSM driving sel,
// tag pipeline with abort kill, block accumulator and rounded result.
module satd_accumulator
  import satd_pkg::*;
#(
  parameter int LENGTH = 12,
  parameter int BEATS  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic signed [LENGTH+4:0]             htv_0,
  input  logic signed [LENGTH+4:0]             htv_1,
  input  logic signed [LENGTH+4:0]             htv_2,
  input  logic signed [LENGTH+4:0]             htv_3,
  input  logic signed [LENGTH+4:0]             htv_4,
  input  logic signed [LENGTH+4:0]             htv_5,
  input  logic signed [LENGTH+4:0]             htv_6,
  input  logic signed [LENGTH+4:0]             htv_7,
  input  logic                                 abort,
  output logic                                 sel,
  output logic                                 busy,
  output logic                                 satd_valid,
  output logic [acc_w(LENGTH, BEATS)-1:0]      satd
);

  localparam int IW    = iw(LENGTH);
  localparam int SW    = IW + 3;
  localparam int ACC_W = acc_w(LENGTH, BEATS);
  localparam int CW    = clog2(BEATS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [ACC_W:0] RND      = (ACC_W + 1)'(rnd_bias(SHIFT));

  state_e            state_q, state_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              p1_valid_q, p1_first_q, p1_last_q;
  logic              p1_valid_d, p1_first_d, p1_last_d;
  logic              p2_valid_q, p2_first_q, p2_last_q;
  logic              p2_valid_d, p2_first_d, p2_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d, satd_q, satd_d;
  logic              satd_valid_q, satd_valid_d;
  logic              accept_s, kill_p1_s, kill_p2_s, s3_fire_s;
  logic [SW-1:0]     sum_s;
  logic [ACC_W-1:0]  total_s;
  logic [ACC_W:0]    rnd_s;
  logic signed [IW-1:0] x_s [NUM_COEF];

  assign x_s = '{htv_0, htv_1, htv_2, htv_3, htv_4, htv_5, htv_6, htv_7};

  abs_sum8 #(.IW(IW)) u_abs_sum8 (
    .clk   (clk),
    .rst   (rst),
    .in_en (accept_s),
    .x     (x_s),
    .s1_en (p1_valid_q),
    .sum_q (sum_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_ACC;
        else          state_d = ST_IDLE;
      end
      ST_ACC: begin
        if (abort)                                state_d = ST_IDLE;
        else if (accept_s && beat_cnt_q == LAST_CNT) state_d = ST_IDLE;
        else                                      state_d = ST_ACC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_ACC);
    sel        = beat_cnt_q[0];
    satd       = satd_q;
    satd_valid = satd_valid_q;
  end

  // An abort kills in-flight beats younger than the newest in-flight last beat.
  always_comb begin
    accept_s  = in_valid & ~abort;
    kill_p1_s = abort & ~p1_last_q;
    kill_p2_s = abort & ~p2_last_q & ~(p1_valid_q & p1_last_q);
    s3_fire_s = p2_valid_q & ~kill_p2_s;

    if (abort)                                  beat_cnt_d = {CW{1'b0}};
    else if (accept_s && beat_cnt_q == LAST_CNT) beat_cnt_d = {CW{1'b0}};
    else if (accept_s)                          beat_cnt_d = beat_cnt_q + CNT_ONE;
    else                                        beat_cnt_d = beat_cnt_q;

    p1_valid_d = accept_s;
    p1_first_d = (beat_cnt_q == {CW{1'b0}});
    p1_last_d  = (beat_cnt_q == LAST_CNT);
    p2_valid_d = p1_valid_q & ~kill_p1_s;
    p2_first_d = p1_first_q;
    p2_last_d  = p1_last_q;
  end

  always_comb begin
    if (p2_first_q) total_s = ACC_W'(sum_s);
    else            total_s = acc_q + ACC_W'(sum_s);
    rnd_s = {1'b0, total_s} + RND;

    if (s3_fire_s) acc_d = total_s;
    else           acc_d = acc_q;

    satd_valid_d = s3_fire_s & p2_last_q;
    if (satd_valid_d) satd_d = ACC_W'(rnd_s >> SHIFT);
    else              satd_d = satd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q   <= '0;
      p1_valid_q   <= 1'b0;
      p1_first_q   <= 1'b0;
      p1_last_q    <= 1'b0;
      p2_valid_q   <= 1'b0;
      p2_first_q   <= 1'b0;
      p2_last_q    <= 1'b0;
      acc_q        <= '0;
      satd_q       <= '0;
      satd_valid_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      p1_valid_q   <= p1_valid_d;
      p1_first_q   <= p1_first_d;
      p1_last_q    <= p1_last_d;
      p2_valid_q   <= p2_valid_d;
      p2_first_q   <= p2_first_d;
      p2_last_q    <= p2_last_d;
      acc_q        <= acc_d;
      satd_q       <= satd_d;
      satd_valid_q <= satd_valid_d;
    end
  end

endmodule
